// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: opcode encodings, FSM states, default width.
package alu_pkg;

  localparam int unsigned ALU_W = 32;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOP = 3'b101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_t;

  function automatic logic op_is_legal(input logic [2:0] op);
    return op <= OP_XOR;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester above ptr, wrapping modulo N.
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  // NOTE: every output gets a default before the search loop so no path
  // through this block can leave a value unassigned and infer a latch.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = 1; k <= N; k++) begin
      if (!any && req[(int'(ptr) + k) % N]) begin
        any                          = 1'b1;
        grant[(int'(ptr) + k) % N]   = 1'b1;
        idx                          = IW'((int'(ptr) + k) % N);
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU between N requesters with one-cycle response pulses.
// Optional opcode checking is enabled by defining ALU_ARB_OPCHK_EN.
import alu_pkg::*;

module alu_arbiter #(
  parameter int N       = 4,
  parameter int ALU_LAT = 1,
  parameter int W       = ALU_W
) (
  input  logic           clock,
  input  logic           clear,
  input  logic [N-1:0]   req_valid,
  output logic [N-1:0]   req_ready,
  input  logic [N*W-1:0] req_a,
  input  logic [N*W-1:0] req_b,
  input  logic [N*3-1:0] req_op,
  output logic [N-1:0]   resp_valid,
  output logic [W-1:0]   resp_result,
  output logic           resp_zero,
  output logic           resp_err,
  output logic [W-1:0]   alu_a,
  output logic [W-1:0]   alu_b,
  output logic [2:0]     alu_op,
  input  logic [W-1:0]   alu_result,
  input  logic           alu_zero,
  output logic           busy
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT + 1) : 1;

  arb_state_t    state_q, state_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  alu_a_q, alu_a_d;
  logic [W-1:0]  alu_b_q, alu_b_d;
  logic [2:0]    alu_op_q, alu_op_d;
  logic [W-1:0]  res_q, res_d;
  logic          zero_q, zero_d;
  logic          err_q, err_d;

  logic [N-1:0]  pick_grant;
  logic [IW-1:0] pick_idx;
  logic          pick_any;
  logic [W-1:0]  sel_a, sel_b;
  logic [2:0]    sel_op;

  rr_arbiter #(.N(N)) u_rr (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  assign sel_a  = req_a[int'(pick_idx)*W +: W];
  assign sel_b  = req_b[int'(pick_idx)*W +: W];
  assign sel_op = req_op[int'(pick_idx)*3 +: 3];

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    alu_op_d = alu_op_q;
    res_d    = res_q;
    zero_d   = zero_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          owner_d  = pick_idx;
          rr_ptr_d = pick_idx;
`ifdef ALU_ARB_OPCHK_EN
          // Illegal opcodes never reach the ALU; answer directly with an error.
          if (!op_is_legal(sel_op)) begin
            res_d   = '0;
            zero_d  = 1'b1;
            err_d   = 1'b1;
            state_d = RESP;
          end else
`endif
          begin
            alu_a_d  = sel_a;
            alu_b_d  = sel_b;
            alu_op_d = sel_op;
            cnt_d    = CW'(ALU_LAT);
            state_d  = ISSUE;
          end
        end
      end
      ISSUE: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          res_d   = alu_result;
          zero_d  = alu_zero;
          err_d   = 1'b0;
          state_d = RESP;
        end
      end
      RESP: begin
        alu_a_d  = '0;
        alu_b_d  = '0;
        alu_op_d = OP_NOP;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q  <= IDLE;
      rr_ptr_q <= IW'(N - 1);
      owner_q  <= '0;
      cnt_q    <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= OP_NOP;
      res_q    <= '0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      alu_op_q <= alu_op_d;
      res_q    <= res_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    resp_valid = '0;
    if (state_q == RESP) resp_valid[owner_q] = 1'b1;
  end

  assign req_ready   = (state_q == IDLE) ? pick_grant : '0;
  assign busy        = (state_q != IDLE);
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_op      = alu_op_q;
  assign resp_result = res_q;
  assign resp_zero   = zero_q;
`ifdef ALU_ARB_OPCHK_EN
  assign resp_err    = err_q;
`else
  assign resp_err    = 1'b0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: a 4-requester ALU_LAT=1 instance and a 2-requester ALU_LAT=3 instance.
`timescale 1ns/1ps
import alu_pkg::*;

module tb_alu_arbiter;

  localparam int N   = 4;
  localparam int W   = 32;
  localparam int LAT = 1;

  typedef struct {
    int         idx;
    logic [W-1:0] res;
    logic       zero;
    logic       err;
  } exp_t;

  logic           clock = 1'b0;
  logic           clear = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a, req_b;
  logic [N*3-1:0] req_op;
  logic [N-1:0]   resp_valid;
  logic [W-1:0]   resp_result;
  logic           resp_zero, resp_err, busy;
  logic [W-1:0]   alu_a, alu_b, alu_result;
  logic [2:0]     alu_op;
  logic           alu_zero;

  logic [1:0]     req_valid3 = '0;
  logic [1:0]     req_ready3, resp_valid3;
  logic [2*W-1:0] req_a3 = '0, req_b3 = '0;
  logic [5:0]     req_op3 = '0;
  logic [W-1:0]   resp_result3, alu_a3, alu_b3, alu_result3, s1, s2;
  logic           resp_zero3, resp_err3, busy3, alu_zero3;
  logic [2:0]     alu_op3;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int n_resp = 0;
  logic [W-1:0] a_v [N];
  logic [W-1:0] b_v [N];
  logic [2:0]   op_v [N];
  int ops_req  [N] = '{default: 0};
  int ops_done [N] = '{default: 0};
  int grant_log [$];
  int hs_cyc_log [$];
  int resp_cyc_log [$];
  exp_t sb [$];
  exp_t e_mon;

  always #5 clock = ~clock;

  function automatic logic [W-1:0] alu_model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      default: return '0;
    endcase
  endfunction

  assign alu_result = alu_model(alu_op, alu_a, alu_b);
  assign alu_zero   = (alu_result == '0);

  always @(posedge clock) begin
    s1 <= alu_model(alu_op3, alu_a3, alu_b3);
    s2 <= s1;
  end
  assign alu_result3 = s2;
  assign alu_zero3   = (s2 == '0);

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = a_v[i];
      req_b[i*W +: W] = b_v[i];
      req_op[i*3 +: 3] = op_v[i];
    end
  end

  alu_arbiter #(.N(N), .ALU_LAT(LAT), .W(W)) u_dut (
    .clock(clock), .clear(clear), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .resp_valid(resp_valid),
    .resp_result(resp_result), .resp_zero(resp_zero), .resp_err(resp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .alu_zero(alu_zero), .busy(busy)
  );

  alu_arbiter #(.N(2), .ALU_LAT(3), .W(W)) u_dut3 (
    .clock(clock), .clear(clear), .req_valid(req_valid3), .req_ready(req_ready3),
    .req_a(req_a3), .req_b(req_b3), .req_op(req_op3), .resp_valid(resp_valid3),
    .resp_result(resp_result3), .resp_zero(resp_zero3), .resp_err(resp_err3),
    .alu_a(alu_a3), .alu_b(alu_b3), .alu_op(alu_op3), .alu_result(alu_result3),
    .alu_zero(alu_zero3), .busy(busy3)
  );

  always @(posedge clock) cyc++;

  // Requester model: hold valid while ops remain, count handshakes seen pre-edge.
  always @(posedge clock) begin
    #1;
    for (int i = 0; i < N; i++) req_valid[i] = (ops_req[i] > ops_done[i]);
  end

  always @(negedge clock) begin
    for (int i = 0; i < N; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        ops_done[i]++;
        grant_log.push_back(i);
        hs_cyc_log.push_back(cyc);
      end
    end
  end

  // Response monitor: every pulse pops the next expected entry.
  always @(negedge clock) begin
    if (resp_valid !== '0) begin
      n_resp++;
      resp_cyc_log.push_back(cyc);
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_resp: resp_valid=%b result=%0d, nothing expected", resp_valid, resp_result);
      end else begin
        e_mon = sb.pop_front();
        if (resp_valid !== N'(1 << e_mon.idx) || resp_result !== e_mon.res ||
            resp_zero !== e_mon.zero || resp_err !== e_mon.err) begin
          n_bad++;
          $display("FAIL resp: got valid=%b result=%0d zero=%b err=%b, expected valid=%b result=%0d zero=%b err=%b",
                   resp_valid, resp_result, resp_zero, resp_err, N'(1 << e_mon.idx), e_mon.res, e_mon.zero, e_mon.err);
        end
      end
    end
  end

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
    a_v[i] = a; b_v[i] = b; op_v[i] = op;
  endtask

  task automatic push_exp(input int i, input logic [W-1:0] r, input logic z, input logic e);
    exp_t x;
    x.idx = i; x.res = r; x.zero = z; x.err = e;
    sb.push_back(x);
  endtask

  task automatic do_reset();
    @(posedge clock); #1 clear = 1'b1;
    repeat (2) @(posedge clock);
    #1 clear = 1'b0;
  endtask

  task automatic wait_resp(input int target, input string name);
    int k;
    for (k = 0; k < 100 && n_resp < target; k++) @(negedge clock);
    @(negedge clock);
    n_cmp++;
    if (n_resp < target) begin
      n_bad++;
      $display("FAIL %s_timeout: responses=%0d, required=%0d", name, n_resp, target);
    end
  endtask

  task automatic wait_ready(input int i, output int hs, input string name);
    int k;
    hs = -1;
    for (k = 0; k < 50; k++) begin
      @(negedge clock);
      if (req_ready[i] === 1'b1) begin hs = cyc; break; end
    end
    n_cmp++;
    if (hs < 0) begin
      n_bad++;
      $display("FAIL %s_no_grant: req_ready[%0d] never rose", name, i);
    end
  endtask

  task automatic check_order(input int base, input int exp_q [$], input string name);
    for (int k = 0; k < exp_q.size(); k++) begin
      n_cmp++;
      if (base + k >= grant_log.size()) begin
        n_bad++;
        $display("FAIL %s_order[%0d]: no grant recorded, required %0d", name, k, exp_q[k]);
      end else if (grant_log[base + k] !== exp_q[k]) begin
        n_bad++;
        $display("FAIL %s_order[%0d]: granted %0d, required %0d", name, k, grant_log[base + k], exp_q[k]);
      end
    end
  endtask

  task automatic check_gaps(input int base, input int count, input int gap, input string name);
    for (int k = 1; k < count; k++) begin
      n_cmp++;
      if (base + k >= hs_cyc_log.size() || hs_cyc_log[base + k] - hs_cyc_log[base + k - 1] != gap) begin
        n_bad++;
        $display("FAIL %s_gap[%0d]: handshake spacing wrong, required %0d cycles", name, k, gap);
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clock);
    n_cmp++;
    if (req_ready !== '0 || resp_valid !== '0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl: ready=%b valid=%b busy=%b, required 0/0/0", req_ready, resp_valid, busy);
    end
    n_cmp++;
    if (resp_result !== '0 || resp_zero !== 1'b0 || resp_err !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_resp: result=%0d zero=%b err=%b, required 0/0/0", resp_result, resp_zero, resp_err);
    end
    n_cmp++;
    if (alu_a !== '0 || alu_b !== '0 || alu_op !== OP_NOP || alu_op3 !== OP_NOP || busy3 !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_alu: a=%0d b=%0d op=%b op3=%b busy3=%b, required 0/0/101/101/0", alu_a, alu_b, alu_op, alu_op3, busy3);
    end
  endtask

  task automatic test_single();
    int hs, r0;
    r0 = n_resp;
    set_op(0, 805, 302, OP_ADD);
    push_exp(0, 1107, 1'b0, 1'b0);
    ops_req[0]++;
    wait_ready(0, hs, "single");
    @(negedge clock);
    n_cmp++;
    if (req_ready !== '0 || alu_a !== 805 || alu_b !== 302 || alu_op !== OP_ADD) begin
      n_bad++;
      $display("FAIL single_issue: ready=%b a=%0d b=%0d op=%b, required 0000/805/302/000", req_ready, alu_a, alu_b, alu_op);
    end
    wait_resp(r0 + 1, "single");
    n_cmp++;
    if (resp_cyc_log.size() <= r0 || resp_cyc_log[r0] - hs != LAT + 1) begin
      n_bad++;
      $display("FAIL single_latency: response not %0d cycles after handshake", LAT + 1);
    end
  endtask

  task automatic test_two();
    int r0, g0;
    r0 = n_resp; g0 = grant_log.size();
    set_op(2, 805, 805, OP_SUB);
    set_op(1, 805, 302, OP_OR);
    push_exp(1, 815, 1'b0, 1'b0);
    push_exp(2, 0, 1'b1, 1'b0);
    ops_req[1]++; ops_req[2]++;
    wait_resp(r0 + 2, "two");
    check_order(g0, '{1, 2}, "two");
  endtask

  task automatic test_all4();
    int r0, g0;
    do_reset();
    r0 = n_resp; g0 = grant_log.size();
    for (int i = 0; i < N; i++) set_op(i, 805, 302, OP_XOR);
    foreach (grant_log[k]) ;
    push_exp(0, 523, 1'b0, 1'b0);
    push_exp(1, 523, 1'b0, 1'b0);
    push_exp(2, 523, 1'b0, 1'b0);
    push_exp(3, 523, 1'b0, 1'b0);
    push_exp(0, 523, 1'b0, 1'b0);
    ops_req[0] += 2; ops_req[1]++; ops_req[2]++; ops_req[3]++;
    wait_resp(r0 + 5, "all4");
    check_order(g0, '{0, 1, 2, 3, 0}, "all4");
    check_gaps(g0, 5, LAT + 2, "all4");
  endtask

  task automatic test_back_to_back();
    int r0, g0;
    r0 = n_resp; g0 = grant_log.size();
    set_op(0, 805, 302, OP_ADD);
    repeat (3) push_exp(0, 1107, 1'b0, 1'b0);
    ops_req[0] += 3;
    wait_resp(r0 + 3, "b2b");
    check_order(g0, '{0, 0, 0}, "b2b");
    check_gaps(g0, 3, LAT + 2, "b2b");
  endtask

  task automatic test_clear_mid();
    int hs, r0, g0;
    set_op(2, 805, 302, OP_ADD);
    ops_req[2]++;
    wait_ready(2, hs, "clear");
    @(posedge clock); #1 clear = 1'b1;
    @(posedge clock); #1 clear = 1'b0;
    @(negedge clock);
    n_cmp++;
    if (busy !== 1'b0 || resp_valid !== '0 || resp_result !== '0 || alu_op !== OP_NOP || alu_a !== '0) begin
      n_bad++;
      $display("FAIL clear_state: busy=%b valid=%b result=%0d op=%b a=%0d, required 0/0/0/101/0", busy, resp_valid, resp_result, alu_op, alu_a);
    end
    r0 = n_resp; g0 = grant_log.size();
    set_op(0, 805, 302, OP_ADD);
    set_op(3, 805, 302, OP_XOR);
    push_exp(0, 1107, 1'b0, 1'b0);
    push_exp(3, 523, 1'b0, 1'b0);
    ops_req[0]++; ops_req[3]++;
    wait_resp(r0 + 2, "clear");
    check_order(g0, '{0, 3}, "clear");
  endtask

  task automatic test_opchk();
    int hs, r0, lat;
    logic [2:0] exp_op;
    r0 = n_resp;
    set_op(1, 805, 302, 3'b110);
`ifdef ALU_ARB_OPCHK_EN
    push_exp(1, 0, 1'b1, 1'b1);
    exp_op = OP_NOP; lat = 1;
`else
    push_exp(1, 0, 1'b1, 1'b0);
    exp_op = 3'b110; lat = LAT + 1;
`endif
    ops_req[1]++;
    wait_ready(1, hs, "opchk");
    @(negedge clock);
    n_cmp++;
    if (alu_op !== exp_op) begin
      n_bad++;
      $display("FAIL opchk_alu_op: alu_op=%b, required %b", alu_op, exp_op);
    end
    wait_resp(r0 + 1, "opchk");
    n_cmp++;
    if (resp_cyc_log.size() <= r0 || resp_cyc_log[r0] - hs != lat) begin
      n_bad++;
      $display("FAIL opchk_latency: response not %0d cycles after handshake", lat);
    end
  endtask

  task automatic test_lat3();
    int hs, k;
    req_a3[W +: W] = 805; req_b3[W +: W] = 302; req_op3[3 +: 3] = OP_AND;
    req_a3[0 +: W] = 7;   req_b3[0 +: W] = 9;   req_op3[0 +: 3] = OP_ADD;
    @(posedge clock); #1 req_valid3 = 2'b10;
    hs = -1;
    for (k = 0; k < 50; k++) begin
      @(negedge clock);
      if (req_ready3 === 2'b10) begin hs = cyc; break; end
    end
    @(posedge clock); #1 req_valid3 = 2'b00;
    n_cmp++;
    if (hs < 0) begin
      n_bad++;
      $display("FAIL lat3_no_grant: req_ready3 never showed 10");
    end
    for (int c = 1; c <= 3; c++) begin
      if (c > 1) @(negedge clock); else @(negedge clock);
      n_cmp++;
      if (alu_a3 !== 805 || alu_b3 !== 302 || alu_op3 !== OP_AND || resp_valid3 !== 2'b00 || busy3 !== 1'b1) begin
        n_bad++;
        $display("FAIL lat3_issue[%0d]: a=%0d b=%0d op=%b valid=%b busy=%b, required 805/302/010/00/1", c, alu_a3, alu_b3, alu_op3, resp_valid3, busy3);
      end
    end
    @(negedge clock);
    n_cmp++;
    if (resp_valid3 !== 2'b10 || resp_result3 !== 292 || resp_zero3 !== 1'b0 || resp_err3 !== 1'b0 || cyc - hs != 4) begin
      n_bad++;
      $display("FAIL lat3_resp: valid=%b result=%0d zero=%b err=%b after %0d cycles, required 10/292/0/0 after 4", resp_valid3, resp_result3, resp_zero3, resp_err3, cyc - hs);
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) set_op(i, '0, '0, OP_NOP);
    repeat (3) @(posedge clock);
    test_reset();
    #1 clear = 1'b0;
    test_single();
    test_two();
    test_all4();
    test_back_to_back();
    test_clear_mid();
    test_opchk();
    test_lat3();
    repeat (3) @(negedge clock);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d expected responses never arrived, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one ALU instance (32-bit operands, 3-bit opcode, 32-bit result, zero flag) between N requesters.
- Round-robin arbitration with a per-requester valid/ready request handshake.
- Sequences each operation through the ALU and returns result and zero to the granted requester as a one-cycle response pulse.
- Sits between the datapath clients and the ALU; it is the only driver of the ALU operand and opcode inputs.

Parameters:
- N, 4, number of requesters (2..8).
- ALU_LAT, 1, clock cycles from stable ALU inputs to valid alu_result/alu_zero (>=1).
- W, 32, operand/result width.

Ports:
- clock  input  1  system clock, rising edge.
- clear  input  1  synchronous active-high reset.
- req_valid  input  N  request valid, one bit per requester.
- req_ready  output  N  request accepted, one-hot or zero.
- req_a  input  N*W  operand A per requester; requester i occupies bits [i*W +: W].
- req_b  input  N*W  operand B per requester, packed the same way.
- req_op  input  N*3  opcode per requester; requester i occupies bits [i*3 +: 3].
- resp_valid  output  N  one-hot, one-cycle response pulse to the owning requester.
- resp_result  output  W  result of the completed operation.
- resp_zero  output  1  ALU zero flag of the completed operation.
- resp_err  output  1  opcode rejected (only when ALU_ARB_OPCHK_EN is defined; otherwise tied 0).
- alu_a  output  W  to ALU inputA.
- alu_b  output  W  to ALU inputB.
- alu_op  output  3  to ALU opCode.
- alu_result  input  W  from ALU result.
- alu_zero  input  1  from ALU zero.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- One clock; clear is synchronous, active-high and overrides all other inputs.
- Reset values:
  - state=IDLE, rr_ptr=N-1, counter=0.
  - req_ready=0, resp_valid=0, resp_result=0, resp_zero=0, resp_err=0, busy=0.
  - alu_a=0, alu_b=0, alu_op=3'b101 (NOP).
- IDLE:
  - req_ready is combinational: one-hot on the first i with req_valid[i]=1, searching from rr_ptr+1 upward and wrapping modulo N.
  - req_ready=0 when no request is valid.
  - Handshake on the edge where req_valid[g]&req_ready[g]: latch g, a, b, op; drive alu_a/alu_b/alu_op from the latched copies; rr_ptr<=g; counter<=ALU_LAT; go to ISSUE.
- ISSUE:
  - alu_* held constant.
  - Counter decrements each edge.
  - On the edge where counter==1: capture resp_result<=alu_result and resp_zero<=alu_zero; go to RESP.
- RESP:
  - resp_valid[g]=1 for exactly one cycle.
  - resp_result/resp_zero hold their value until the next capture.
  - Next edge: go to IDLE; alu_op returns to NOP and alu_a/alu_b return to 0.
- req_ready is 0 in ISSUE and RESP. Requesters hold req_valid and operands until they see req_ready.
- Latency: handshake at edge T -> resp_valid high in cycle T+ALU_LAT+1. Throughput is one op per ALU_LAT+2 cycles.
- Responses have no backpressure; the requester samples them in the pulse cycle.
- A requester may drop req_valid before it is granted without penalty. It may re-request in the same cycle its resp_valid is high; that request is seen in the following IDLE cycle.
- Fairness:
  - rr_ptr advances only on a grant.
  - With all N requesting continuously, grants go 0,1,..,N-1,0,...
  - A single requester is granted every op slot.
- Opcodes 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR. Without the optional feature, all opcodes are forwarded unchanged.
- clear mid-operation: the in-flight op is dropped, no resp_valid is issued, rr_ptr returns to N-1.

Optional Feature:
- Macro: ALU_ARB_OPCHK_EN.
- Defined:
  - A granted opcode in 101..111 bypasses the ALU: state goes IDLE->RESP directly and alu_* stay idle.
  - Response is resp_result=0, resp_zero=1, resp_err=1, resp_valid[g] pulsed at T+1.
  - Legal opcodes give resp_err=0.
- Undefined: all opcodes go through the ALU, and resp_err is constant 0.

Decomposition:
- Package alu_pkg:
  - opcode localparams OP_ADD=000, OP_SUB=001, OP_AND=010, OP_OR=011, OP_XOR=100, OP_NOP=101.
  - state encoding IDLE/ISSUE/RESP.
  - default width 32.
- Sub-module rr_arbiter holds the combinational round-robin pick: (req, ptr) -> one-hot grant plus index. It is reused elsewhere for other shared units.

Test Plan:
- Single requester 0: a=805, b=302, op=000 -> req_ready[0] one cycle; resp_valid[0] at T+ALU_LAT+1 with result=1107, zero=0.
- Requester 2: a=805, b=805, op=001 -> result=0, zero=1; requester 1 concurrently: a=805, b=302, op=011. With rr_ptr=N-1 after reset, requester 1 is served first (result=815), then requester 2.
- All 4 requesting continuously with XOR 805^302 -> grant order 0,1,2,3,0; each response is 523 to the correct requester index only.
- clear asserted during ISSUE -> next cycle all outputs at reset values, no resp_valid; a new request after clear is granted to requester 0 first.
- With ALU_ARB_OPCHK_EN defined, op=110 -> no ALU activity, resp_valid at T+1 with result=0, zero=1, err=1. Without the macro -> forwarded, result 0 from the ALU NOP, err=0.
- ALU_LAT=3, op=010, 805&302 -> response 292 exactly 4 cycles after the handshake; alu_a/b/op stable for all 3 ISSUE cycles.
